// File: rtl/register_file_sb_pkg.sv
// -----------------------------------------------------------------------------
// register_file_sb_pkg
// Shared definitions for the MIPS general-purpose register file:
//   - reg_idx_t      : 5-bit architectural register index
//   - ZERO/GP/SP/RA  : well-known register indices
//   - *_RESET_DEFAULT: power-on contents of $sp and $gp
//   - idx_hit()      : "a write to a non-zero register matches this read index"
// -----------------------------------------------------------------------------
package register_file_sb_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int NUM_REGS = 32;

  localparam reg_idx_t ZERO = 5'd0;
  localparam reg_idx_t GP   = 5'd28;
  localparam reg_idx_t SP   = 5'd29;
  localparam reg_idx_t RA   = 5'd31;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_RESET_DEFAULT = 32'h1000_8000;

  // Register 0 is hard-wired, so a write aimed at it can never match a read.
  function automatic logic idx_hit(input logic     en,
                                   input reg_idx_t wr_idx,
                                   input reg_idx_t rd_idx);
    return en && (wr_idx == rd_idx) && (rd_idx != ZERO);
  endfunction

endpackage

// File: rtl/register_file_sb_decoder.sv
// -----------------------------------------------------------------------------
// Decoder_Register_File
// 5-to-32 one-hot decoder used to qualify register-file writes and scoreboard
// updates.
// Ports:
//   enable : when low, the select vector is all zeros
//   index  : register index to decode
//   select : one-hot select, bit n set when enable=1 and index=n
// -----------------------------------------------------------------------------
module Decoder_Register_File
  import register_file_sb_pkg::*;
(
  input  logic                enable,
  input  reg_idx_t            index,
  output logic [NUM_REGS-1:0] select
);

  always_comb begin
    select = '0;
    if (enable) begin
      select[index] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
// 32 x DATA_WIDTH MIPS register file with two combinational read ports, one
// write port, optional write-to-read bypass and a pending-write scoreboard.
// Ports:
//   clk, reset                      : rising-edge clock, async active-high reset
//   reg_write_i / write_register_i  : writeback enable and destination index
//   write_data_i                    : writeback data
//   read_register_{1,2}_i           : source indices (rs, rt)
//   read_data_{1,2}_o               : operand data (combinational)
//   issue_i / issue_register_i      : destination of an instruction leaving decode
//   busy_{1,2}_o                    : operand still waits on an outstanding write
//   pending_o                       : scoreboard, bit n = register n pending
// -----------------------------------------------------------------------------
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(SP_RESET_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = DATA_WIDTH'(GP_RESET_DEFAULT),
  parameter bit                    BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_i,
  input  reg_idx_t              write_register_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  reg_idx_t              read_register_1_i,
  input  reg_idx_t              read_register_2_i,
  output logic [DATA_WIDTH-1:0] read_data_1_o,
  output logic [DATA_WIDTH-1:0] read_data_2_o,
  input  logic                  issue_i,
  input  reg_idx_t              issue_register_i,
  output logic                  busy_1_o,
  output logic                  busy_2_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  logic [NUM_REGS-1:0]   write_select;
  logic [NUM_REGS-1:0]   issue_select;
  logic [NUM_REGS-1:0]   pending;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic write_hit_1;
  logic write_hit_2;
  logic bypass_1;
  logic bypass_2;

  Decoder_Register_File u_write_decoder (
    .enable (reg_write_i),
    .index  (write_register_i),
    .select (write_select)
  );

  Decoder_Register_File u_issue_decoder (
    .enable (issue_i),
    .index  (issue_register_i),
    .select (issue_select)
  );

  // Storage: register 0 is never written, so it keeps its reset value of 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[GP] <= GP_RESET;
      regs[SP] <= SP_RESET;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (write_select[i]) begin
          regs[i] <= write_data_i;
        end
      end
    end
  end

  // Scoreboard: the retiring write clears first, then a new issue sets, so a
  // same-cycle issue to the register being written leaves it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~write_select) | issue_select) & ~NUM_REGS'(1);
    end
  end

  assign pending_o = pending;

  // Read ports. While reset is held the writeback bus is ignored so the ports
  // show the reset contents and nothing reads as busy.
  always_comb begin
    write_hit_1 = !reset && idx_hit(reg_write_i, write_register_i, read_register_1_i);
    write_hit_2 = !reset && idx_hit(reg_write_i, write_register_i, read_register_2_i);
    bypass_1    = BYPASS_EN && write_hit_1;
    bypass_2    = BYPASS_EN && write_hit_2;

    read_data_1_o = bypass_1 ? write_data_i : regs[read_register_1_i];
    read_data_2_o = bypass_2 ? write_data_i : regs[read_register_2_i];

    // Without bypass the value being written is not visible until the next
    // cycle, so a matching write keeps the operand busy for this cycle.
    if (BYPASS_EN) begin
      busy_1_o = pending[read_register_1_i] && !bypass_1;
      busy_2_o = pending[read_register_2_i] && !bypass_2;
    end else begin
      busy_1_o = pending[read_register_1_i] || write_hit_1;
      busy_2_o = pending[read_register_2_i] || write_hit_2;
    end
  end

endmodule
